// File: rtl/uart_apb_ctrl.sv
// uart_apb_ctrl: APB master that configures uart_top and moves bytes.
// Optional ACCESS-phase timeout: define UART_CTRL_TIMEOUT_EN.
module uart_apb_ctrl #(
  parameter int          APB_ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          RXEMPTY_BIT    = 0,
  parameter int          TXFULL_BIT     = 1,
  parameter int          POLL_INTERVAL  = 16,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic [31:0]               mode_i,
  input  logic [31:0]               intc_i,
  input  logic                      tx_valid_i,
  input  logic [7:0]                tx_data_i,
  output logic                      tx_ready_o,
  output logic                      rx_valid_o,
  output logic [7:0]                rx_data_o,
  input  logic                      rx_ready_i,
  input  logic                      int_i,
  output logic [APB_ADDR_WIDTH-1:0] apb_addr_o,
  output logic                      apb_sel_o,
  output logic                      apb_en_o,
  output logic                      apb_wr_o,
  output logic [31:0]               apb_wdata_o,
  output logic [3:0]                apb_strb_o,
  input  logic [31:0]               apb_rdata_i,
  input  logic                      apb_ready_i,
  input  logic                      apb_err_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int AW = APB_ADDR_WIDTH;
  localparam logic [AW-1:0] A_INTF = BASE_ADDR[AW-1:0];
  localparam logic [AW-1:0] A_INTC = A_INTF + AW'(4);
  localparam logic [AW-1:0] A_MODE = A_INTF + AW'(8);
  localparam logic [AW-1:0] A_STAT = A_INTF + AW'(12);
  localparam logic [AW-1:0] A_RXB  = A_INTF + AW'(16);
  localparam logic [AW-1:0] A_TXB  = A_INTF + AW'(20);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_MODE, S_CFG_INTC, S_CLR_INTF,
    S_WAIT, S_POLL, S_RXRD, S_TXWR, S_INTCLR
  } state_t;

  state_t          r_state, w_state_n;
  logic            r_sel, w_sel_n;
  logic            r_en, w_en_n;
  logic [AW-1:0]   r_addr, w_addr_n;
  logic            r_wr, w_wr_n;
  logic [31:0]     r_wdata, w_wdata_n;
  logic [3:0]      r_strb, w_strb_n;
  logic [31:0]     r_mode, w_mode_n;
  logic [31:0]     r_intc, w_intc_n;
  logic            r_tx_full, w_tx_full_n;
  logic [7:0]      r_tx_data, w_tx_data_n;
  logic            r_rx_valid, w_rx_valid_n;
  logic [7:0]      r_rx_data, w_rx_data_n;
  logic [15:0]     r_cnt, w_cnt_n;
  logic            r_int, w_int_n;
  logic            r_err, w_err_n;
  logic            r_start_pend, w_start_pend_n;
  logic            r_stop_pend, w_stop_pend_n;

  logic            w_run, w_tx_ready, w_done, w_xerr, w_tout;
  logic            w_start, w_stop, w_bound;
  logic [AW-1:0]   w_xa;
  logic            w_xw;
  logic [31:0]     w_xd;

`ifdef UART_CTRL_TIMEOUT_EN
  logic [15:0] r_tcnt;
  assign w_tout = r_sel && r_en && !apb_ready_i &&
                  (r_tcnt == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_tcnt <= '0;
    else if (r_sel && r_en && !w_done)
      r_tcnt <= r_tcnt + 16'd1;
    else
      r_tcnt <= '0;
  end
`else
  assign w_tout = 1'b0;
`endif

  assign w_run = (r_state == S_WAIT) || (r_state == S_POLL) ||
                 (r_state == S_RXRD) || (r_state == S_TXWR) ||
                 (r_state == S_INTCLR);
  assign w_tx_ready = w_run && !r_tx_full;
  assign w_done  = r_sel && r_en && (apb_ready_i || w_tout);
  // A completion without PREADY can only be a timeout abort
  assign w_xerr  = w_done && (apb_ready_i ? apb_err_i : 1'b1);
  assign w_start = start_i || r_start_pend;
  assign w_stop  = stop_i || r_stop_pend;
  assign w_bound = !r_sel || w_done;

  always_comb begin
    w_xa = A_INTF;
    w_xw = 1'b1;
    w_xd = '1;
    unique case (r_state)
      S_CFG_MODE: w_xd = r_mode;
      S_CFG_INTC: begin
        w_xa = A_INTC;
        w_xd = r_intc;
      end
      S_POLL: begin
        w_xa = A_STAT;
        w_xw = 1'b0;
        w_xd = '0;
      end
      S_RXRD: begin
        w_xa = A_RXB;
        w_xw = 1'b0;
        w_xd = '0;
      end
      S_TXWR: begin
        w_xa = A_TXB;
        w_xd = {24'h0, r_tx_data};
      end
      default: ;
    endcase
    if (r_state == S_CFG_MODE) w_xa = A_MODE;
  end

  always_comb begin
    w_state_n      = r_state;
    w_sel_n        = r_sel;
    w_en_n         = r_en;
    w_addr_n       = r_addr;
    w_wr_n         = r_wr;
    w_wdata_n      = r_wdata;
    w_strb_n       = r_strb;
    w_mode_n       = r_mode;
    w_intc_n       = r_intc;
    w_tx_full_n    = r_tx_full;
    w_tx_data_n    = r_tx_data;
    w_rx_valid_n   = r_rx_valid;
    w_rx_data_n    = r_rx_data;
    w_cnt_n        = r_cnt;
    w_int_n        = r_int;
    w_err_n        = r_err;
    w_start_pend_n = r_start_pend || start_i;
    w_stop_pend_n  = r_stop_pend || stop_i;

    if (start_i) begin
      w_mode_n = mode_i;
      w_intc_n = intc_i;
    end
    if (r_rx_valid && rx_ready_i) w_rx_valid_n = 1'b0;
    if (w_tx_ready && tx_valid_i) begin
      w_tx_full_n = 1'b1;
      w_tx_data_n = tx_data_i;
    end

    if (w_done) begin
      w_sel_n = 1'b0;
      w_en_n  = 1'b0;
      if (w_xerr) w_err_n = 1'b1;
    end else if (r_sel && !r_en) begin
      w_en_n = 1'b1;
    end
    if (w_done && !w_xerr && r_state == S_RXRD) begin
      w_rx_valid_n = 1'b1;
      w_rx_data_n  = apb_rdata_i[7:0];
    end
    // A failed TXBUF write still consumes the byte
    if (w_done && r_state == S_TXWR) w_tx_full_n = 1'b0;

    if (r_state == S_IDLE) begin
      w_start_pend_n = 1'b0;
      w_stop_pend_n  = 1'b0;
      if (start_i) begin
        w_state_n = S_CFG_MODE;
        w_err_n   = 1'b0;
      end
    end else if (w_bound && w_start) begin
      w_state_n      = S_CFG_MODE;
      w_err_n        = 1'b0;
      w_start_pend_n = 1'b0;
      w_stop_pend_n  = 1'b0;
    end else if (w_bound && w_stop) begin
      w_state_n     = S_IDLE;
      w_stop_pend_n = 1'b0;
    end else if (r_state == S_WAIT) begin
      if (int_i || r_tx_full || r_cnt >= 16'(POLL_INTERVAL - 1)) begin
        w_state_n = S_POLL;
        w_cnt_n   = '0;
        w_int_n   = int_i;
      end else begin
        w_cnt_n = r_cnt + 16'd1;
      end
    end else if (!r_sel) begin
      w_sel_n   = 1'b1;
      w_en_n    = 1'b0;
      w_addr_n  = w_xa;
      w_wr_n    = w_xw;
      w_wdata_n = w_xd;
      w_strb_n  = w_xw ? 4'hF : 4'h0;
    end else if (w_done) begin
      w_cnt_n = '0;
      unique case (r_state)
        S_CFG_MODE: w_state_n = S_CFG_INTC;
        S_CFG_INTC: w_state_n = S_CLR_INTF;
        S_POLL: begin
          if (!w_xerr && !apb_rdata_i[RXEMPTY_BIT] && !r_rx_valid)
            w_state_n = S_RXRD;
          else if (!w_xerr && !apb_rdata_i[TXFULL_BIT] && r_tx_full)
            w_state_n = S_TXWR;
          else if (r_int)
            w_state_n = S_INTCLR;
          else
            w_state_n = S_WAIT;
        end
        default: w_state_n = S_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_en         <= 1'b0;
      r_addr       <= '0;
      r_wr         <= 1'b0;
      r_wdata      <= '0;
      r_strb       <= '0;
      r_mode       <= '0;
      r_intc       <= '0;
      r_tx_full    <= 1'b0;
      r_tx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_data    <= '0;
      r_cnt        <= '0;
      r_int        <= 1'b0;
      r_err        <= 1'b0;
      r_start_pend <= 1'b0;
      r_stop_pend  <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_sel        <= w_sel_n;
      r_en         <= w_en_n;
      r_addr       <= w_addr_n;
      r_wr         <= w_wr_n;
      r_wdata      <= w_wdata_n;
      r_strb       <= w_strb_n;
      r_mode       <= w_mode_n;
      r_intc       <= w_intc_n;
      r_tx_full    <= w_tx_full_n;
      r_tx_data    <= w_tx_data_n;
      r_rx_valid   <= w_rx_valid_n;
      r_rx_data    <= w_rx_data_n;
      r_cnt        <= w_cnt_n;
      r_int        <= w_int_n;
      r_err        <= w_err_n;
      r_start_pend <= w_start_pend_n;
      r_stop_pend  <= w_stop_pend_n;
    end
  end

  assign tx_ready_o  = w_tx_ready;
  assign rx_valid_o  = r_rx_valid;
  assign rx_data_o   = r_rx_data;
  assign apb_addr_o  = r_addr;
  assign apb_sel_o   = r_sel;
  assign apb_en_o    = r_en;
  assign apb_wr_o    = r_wr;
  assign apb_wdata_o = r_wdata;
  assign apb_strb_o  = r_strb;
  assign busy_o      = (r_state != S_IDLE);
  assign err_o       = r_err;

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// tb_uart_apb_ctrl: directed bench for uart_apb_ctrl
// with a behavioural uart_top APB slave.
module tb_uart_apb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, stop_i = 1'b0;
  logic [31:0] mode_i = '0, intc_i = '0;
  logic        tx_valid_i = 1'b0;
  logic [7:0]  tx_data_i = '0;
  logic        tx_ready_o, rx_valid_o;
  logic [7:0]  rx_data_o;
  logic        rx_ready_i = 1'b0;
  logic        int_i = 1'b0;
  logic [7:0]  apb_addr_o;
  logic        apb_sel_o, apb_en_o, apb_wr_o;
  logic [31:0] apb_wdata_o, apb_rdata_i;
  logic [3:0]  apb_strb_o;
  logic        apb_ready_i, apb_err_i;
  logic        busy_o, err_o;

  always #5 clk = ~clk;

  uart_apb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .start_i(start_i), .stop_i(stop_i),
    .mode_i(mode_i), .intc_i(intc_i),
    .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i),
    .tx_ready_o(tx_ready_o),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o),
    .rx_ready_i(rx_ready_i), .int_i(int_i),
    .apb_addr_o(apb_addr_o), .apb_sel_o(apb_sel_o),
    .apb_en_o(apb_en_o), .apb_wr_o(apb_wr_o),
    .apb_wdata_o(apb_wdata_o), .apb_strb_o(apb_strb_o),
    .apb_rdata_i(apb_rdata_i), .apb_ready_i(apb_ready_i),
    .apb_err_i(apb_err_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic        w;
    logic [31:0] d;
  } xfer_t;

  typedef struct {
    logic [31:0]      mode;
    logic [31:0]      intc;
    int               ws;
    logic [2:0][7:0]  ea;
    logic [2:0][31:0] ed;
  } cfg_t;

  int total = 0, bad = 0, proto = 0;
  xfer_t log_q[$];

  logic [31:0] s_status = 32'h1, s_rxbuf = '0;
  int          s_wait = 0, acc_cnt = 0;
  logic        s_hold = 1'b0, s_err_en = 1'b0;
  logic [7:0]  s_err_addr = '0;

  assign apb_ready_i = !s_hold && (acc_cnt >= s_wait);
  assign apb_rdata_i = (apb_addr_o == 8'h0C) ? s_status :
                       (apb_addr_o == 8'h10) ? s_rxbuf : 32'h0;
  assign apb_err_i = s_err_en && apb_sel_o && apb_en_o &&
                     (apb_addr_o == s_err_addr);

  always @(posedge clk)
    if (apb_sel_o && apb_en_o && !apb_ready_i) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;

  logic        p_sel = 1'b0, p_done = 1'b0, p_wr = 1'b0;
  logic [7:0]  p_addr = '0;
  logic [31:0] p_wd = '0;
  always @(negedge clk) begin
    if (apb_en_o && !apb_sel_o) proto++;
    if (apb_sel_o && apb_strb_o !== (apb_wr_o ? 4'hF : 4'h0)) proto++;
    if (apb_sel_o && !p_sel && apb_en_o) proto++;
    if (apb_sel_o && p_sel && p_done) proto++;
    if (apb_sel_o && p_sel && !p_done &&
        (apb_addr_o !== p_addr || apb_wr_o !== p_wr ||
         apb_wdata_o !== p_wd)) proto++;
    p_sel  = apb_sel_o;
    p_addr = apb_addr_o;
    p_wr   = apb_wr_o;
    p_wd   = apb_wdata_o;
    p_done = apb_sel_o && apb_en_o && apb_ready_i;
    if (p_done) log_q.push_back({apb_addr_o, apb_wr_o, apb_wdata_o});
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int cnt_addr(input logic [7:0] a);
    int n = 0;
    foreach (log_q[i]) if (log_q[i].a == a) n++;
    return n;
  endfunction

  function automatic int find_idx(input logic [7:0] a, input int n);
    int k = 0;
    foreach (log_q[i])
      if (log_q[i].a == a) begin
        if (k == n) return i;
        k++;
      end
    return -1;
  endfunction

  function automatic xfer_t entry(input int i);
    xfer_t z = '0;
    if (i >= 0 && i < log_q.size()) z = log_q[i];
    return z;
  endfunction

  task automatic pulse_start(input logic [31:0] m, input logic [31:0] c);
    @(negedge clk);
    mode_i  = m;
    intc_i  = c;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    for (int i = 0; i < 100 && busy_o; i++) @(negedge clk);
    chk("stop_idle", 64'(busy_o), 64'd0);
  endtask

  task automatic send_tx(input logic [7:0] b, output bit ok);
    @(negedge clk);
    tx_valid_i = 1'b1;
    tx_data_i  = b;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 tx_valid_i = 1'b0;
  endtask

  task automatic wait_cnt(input logic [7:0] a, input int n, input int lim);
    for (int i = 0; i < lim && cnt_addr(a) < n; i++) @(negedge clk);
  endtask

  cfg_t cv[2];
  bit   ok;
  int   ix, n;
  xfer_t e;

  initial begin
    cv[0].mode = 32'h0000_0186;
    cv[0].intc = 32'h0000_0002;
    cv[0].ws   = 0;
    cv[0].ea   = {8'h00, 8'h04, 8'h08};
    cv[0].ed   = {32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0186};
    cv[1].mode = 32'hDEAD_BEEF;
    cv[1].intc = 32'h0000_0005;
    cv[1].ws   = 2;
    cv[1].ea   = {8'h00, 8'h04, 8'h08};
    cv[1].ed   = {32'hFFFF_FFFF, 32'h0000_0005, 32'hDEAD_BEEF};

    repeat (3) @(negedge clk);
    chk("rst_apb", 64'({apb_sel_o, apb_en_o, apb_wr_o, apb_strb_o}), 64'd0);
    chk("rst_bus", 64'({apb_addr_o, apb_wdata_o}), 64'd0);
    chk("rst_ctl", 64'({busy_o, err_o, tx_ready_o, rx_valid_o}), 64'd0);
    chk("rst_rxd", 64'(rx_data_o), 64'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 2; k++) begin
      if (k > 0) do_stop();
      log_q.delete();
      s_wait = cv[k].ws;
      pulse_start(cv[k].mode, cv[k].intc);
      chk("cfg_busy", 64'(busy_o), 64'd1);
      for (int i = 0; i < 200 && log_q.size() < 3; i++) @(negedge clk);
      for (int j = 0; j < 3; j++)
        chk($sformatf("cfg%0d_wr%0d", k, j), 64'(entry(j)),
            64'({cv[k].ea[j], 1'b1, cv[k].ed[j]}));
    end
    s_wait = 0;

    repeat (20) @(negedge clk);
    log_q.delete();
    @(negedge clk);
    start_i = 1'b1;
    stop_i  = 1'b1;
    mode_i  = 32'h11;
    intc_i  = 32'h1;
    @(negedge clk);
    start_i = 1'b0;
    stop_i  = 1'b0;
    for (int i = 0; i < 100 && cnt_addr(8'h08) < 1; i++) @(negedge clk);
    chk("startstop_mode", 64'(entry(find_idx(8'h08, 0))),
        64'({8'h08, 1'b1, 32'h11}));
    chk("startstop_busy", 64'(busy_o), 64'd1);

    repeat (20) @(negedge clk);
    log_q.delete();
    s_status = 32'h1;
    send_tx(8'h55, ok);
    chk("tx0_acc", 64'(ok), 64'd1);
    @(negedge clk);
    chk("tx_gap", 64'(tx_ready_o), 64'd0);
    send_tx(8'hA3, ok);
    chk("tx1_acc", 64'(ok), 64'd1);
    wait_cnt(8'h14, 2, 200);
    for (int j = 0; j < 2; j++) begin
      ix = find_idx(8'h14, j);
      e = entry(ix);
      chk($sformatf("txbuf%0d", j), 64'({e.a, e.w, e.d}),
          64'({8'h14, 1'b1, (j == 0) ? 32'h55 : 32'hA3}));
      e = entry(ix - 1);
      chk($sformatf("txpoll%0d", j), 64'({e.a, e.w}),
          64'({8'h0C, 1'b0}));
    end

    log_q.delete();
    s_rxbuf  = 32'h7E;
    s_status = 32'h2;
    for (int i = 0; i < 100 && !rx_valid_o; i++) @(negedge clk);
    chk("rx0_valid", 64'(rx_valid_o), 64'd1);
    chk("rx0_data", 64'(rx_data_o), 64'h7E);
    repeat (60) @(negedge clk);
    chk("rx_bp_reads", 64'(cnt_addr(8'h10)), 64'd1);
    chk("rx_hold", 64'({rx_valid_o, rx_data_o}), 64'({1'b1, 8'h7E}));
    s_rxbuf = 32'h31;
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
    for (int i = 0; i < 100 && !rx_valid_o; i++) @(negedge clk);
    chk("rx1_data", 64'({rx_valid_o, rx_data_o}), 64'({1'b1, 8'h31}));
    chk("rx1_reads", 64'(cnt_addr(8'h10)), 64'd2);
    s_status = 32'h1;
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
    repeat (5) @(negedge clk);

    log_q.delete();
    s_status = 32'h3;
    send_tx(8'h99, ok);
    chk("txf_acc", 64'(ok), 64'd1);
    repeat (40) @(negedge clk);
    chk("txf_nowr", 64'(cnt_addr(8'h14)), 64'd0);
    chk("txf_polls", 64'(cnt_addr(8'h0C) >= 3), 64'd1);
    s_status = 32'h1;
    wait_cnt(8'h14, 1, 100);
    chk("txf_wr", 64'(entry(find_idx(8'h14, 0))),
        64'({8'h14, 1'b1, 32'h99}));
    repeat (20) @(negedge clk);
    chk("txf_once", 64'(cnt_addr(8'h14)), 64'd1);

    log_q.delete();
    s_err_en   = 1'b1;
    s_err_addr = 8'h14;
    send_tx(8'hC4, ok);
    wait_cnt(8'h14, 1, 100);
    @(negedge clk);
    chk("err_set", 64'(err_o), 64'd1);
    s_err_en = 1'b0;
    repeat (30) @(negedge clk);
    chk("err_drop", 64'(cnt_addr(8'h14)), 64'd1);
    chk("err_txrdy", 64'(tx_ready_o), 64'd1);
    chk("err_sticky", 64'(err_o), 64'd1);
    pulse_start(32'h186, 32'h2);
    repeat (5) @(negedge clk);
    chk("err_clr", 64'(err_o), 64'd0);

    repeat (20) @(negedge clk);
    log_q.delete();
    int_i = 1'b1;
    for (int i = 0; i < 100 && cnt_addr(8'h00) < 1; i++) @(negedge clk);
    int_i = 1'b0;
    chk("int_clr", 64'(entry(find_idx(8'h00, 0))),
        64'({8'h00, 1'b1, 32'hFFFF_FFFF}));

    do_stop();
    chk("stop_sel", 64'({apb_sel_o, tx_ready_o}), 64'd0);

    pulse_start(32'h186, 32'h2);
    s_hold = 1'b1;
    for (int i = 0; i < 50 && !(apb_sel_o && apb_en_o); i++) @(negedge clk);
    chk("hold_acc", 64'({apb_sel_o, apb_en_o}), 64'd3);
    #2 rst_n = 1'b0;
    #1 chk("arst_sel", 64'({apb_sel_o, apb_en_o, busy_o}), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    s_hold = 1'b0;

`ifdef UART_CTRL_TIMEOUT_EN
    pulse_start(32'h186, 32'h2);
    s_hold = 1'b1;
    for (int i = 0; i < 50 && !apb_en_o; i++) @(negedge clk);
    n = 0;
    for (int i = 0; i < 200 && apb_en_o; i++) begin
      n++;
      @(negedge clk);
    end
    chk("tout_cycles", 64'(n), 64'd64);
    chk("tout_err", 64'({apb_sel_o, err_o}), 64'd1);
    s_hold = 1'b0;
    do_stop();
`endif

    repeat (5) @(negedge clk);
    chk("apb_proto", 64'(proto), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
